// File: rtl/mmio_exmem.sv
// -----------------------------------------------------------------------------
// mmio_exmem
//
// Unified instruction/data memory with a memory-mapped peripheral window.
// Addresses below IO_BASE hit a single RAM that is shared by the data port
// (read/write) and the instruction fetch port (read only). Addresses at or
// above IO_BASE select peripheral registers:
//
//   IO_BASE + 0              RANDOM     rd: LFSR state, wr: reseed (0 -> seed)
//   IO_BASE + 1              STATUS     rd: pending flags, wr: ignored
//   IO_BASE + 2 + i          PVAL[i]    rd: latched player value, clears pending
//   IO_BASE + 2 + NPLAYERS   RANDLATCH  rd/wr: randomVal register
//   anything else in window             rd: 0, wr: ignored
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           data-port enable, qualifies memwrite/memread
//   memwrite     data write strobe
//   memread      data read strobe
//   adr          data address
//   writedata    data write value
//   pc           instruction fetch address (fetched every cycle)
//   p_valid      per-channel producer valid
//   p_data       per-channel producer data, channel i at [i*WIDTH +: WIDTH]
//   memdata      registered data read result (holds when not reading)
//   instruction  registered fetch result
//   randomVal    RANDLATCH register
//   p_ack        one-cycle capture acknowledge per channel
//   irq          OR of all pending flags
// -----------------------------------------------------------------------------
module mmio_exmem #(
    parameter int                   WIDTH     = 16,
    parameter int                   ADDR_BITS = 8,
    parameter int                   NPLAYERS  = 4,
    parameter logic [ADDR_BITS-1:0] IO_BASE   = 8'hF0,
    parameter logic [WIDTH-1:0]     LFSR_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0]     LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      memwrite,
    input  logic                      memread,
    input  logic [ADDR_BITS-1:0]      adr,
    input  logic [WIDTH-1:0]          writedata,
    input  logic [ADDR_BITS-1:0]      pc,
    input  logic [NPLAYERS-1:0]       p_valid,
    input  logic [NPLAYERS*WIDTH-1:0] p_data,
    output logic [WIDTH-1:0]          memdata,
    output logic [WIDTH-1:0]          instruction,
    output logic [WIDTH-1:0]          randomVal,
    output logic [NPLAYERS-1:0]       p_ack,
    output logic                      irq
);

    localparam int DEPTH = int'(IO_BASE);

    // Register offsets inside the peripheral window.
    localparam logic [ADDR_BITS-1:0] OFF_RANDOM    = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] OFF_STATUS    = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] OFF_PVAL      = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] OFF_RANDLATCH = ADDR_BITS'(2 + NPLAYERS);

    // Galois LFSR step. With a nonzero state and a proper tap mask the state
    // can never collapse to zero, so no lock-up recovery is needed.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] nxt;
        nxt = {1'b0, cur[WIDTH-1:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    ram [0:DEPTH-1];

    logic [WIDTH-1:0]    memdata_q,     memdata_d;
    logic [WIDTH-1:0]    instruction_q, instruction_d;
    logic [WIDTH-1:0]    random_val_q,  random_val_d;
    logic [WIDTH-1:0]    lfsr_q,        lfsr_d;
    logic [NPLAYERS-1:0] pending_q,     pending_d;
    logic [NPLAYERS-1:0] p_ack_q,       p_ack_d;
    logic                irq_q,         irq_d;
    logic [WIDTH-1:0]    pval_q [NPLAYERS];
    logic [WIDTH-1:0]    pval_d [NPLAYERS];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                 rd_en_s;
    logic                 wr_en_s;
    logic                 is_io_s;
    logic [ADDR_BITS-1:0] io_off_s;
    logic [NPLAYERS-1:0]  pval_sel_s;
    logic [WIDTH-1:0]     pval_rd_s;
    logic [WIDTH-1:0]     rd_val_s;

    // Strobe qualification and peripheral window offset.
    always_comb begin
        rd_en_s  = en & memread;
        wr_en_s  = en & memwrite;
        is_io_s  = (adr >= IO_BASE);
        io_off_s = adr - IO_BASE;
    end

    // Per-channel PVAL select plus an AND-OR mux of the latched values;
    // at most one select is active so the OR is a plain selection.
    always_comb begin
        pval_sel_s = {NPLAYERS{1'b0}};
        pval_rd_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NPLAYERS; i++) begin
            pval_sel_s[i] = is_io_s && (io_off_s == (OFF_PVAL + ADDR_BITS'(i)));
            pval_rd_s     = pval_rd_s | (pval_q[i] & {WIDTH{pval_sel_s[i]}});
        end
    end

    // Data read mux. RAM is read from the array before any same-edge write
    // lands, which gives read-before-write on address collisions.
    always_comb begin
        rd_val_s = {WIDTH{1'b0}};
        if (!is_io_s) begin
            rd_val_s = ram[adr];
        end else if (io_off_s == OFF_RANDOM) begin
            rd_val_s = lfsr_q;
        end else if (io_off_s == OFF_STATUS) begin
            rd_val_s = WIDTH'(pending_q);
        end else if (io_off_s == OFF_RANDLATCH) begin
            rd_val_s = random_val_q;
        end else begin
            // PVAL hit returns its value; unmapped offsets leave this at 0.
            rd_val_s = pval_rd_s;
        end
    end

    // Data port result holds unless a read is issued; fetch runs every cycle.
    always_comb begin
        memdata_d     = memdata_q;
        instruction_d = {WIDTH{1'b0}};
        if (rd_en_s) begin
            memdata_d = rd_val_s;
        end else begin
            memdata_d = memdata_q;
        end
        if (pc < IO_BASE) begin
            instruction_d = ram[pc];
        end else begin
            instruction_d = {WIDTH{1'b0}};
        end
    end

    // LFSR reseed/step and RANDLATCH load. A zero reseed value would lock
    // the LFSR, so it is replaced by the default seed.
    always_comb begin
        lfsr_d       = lfsr_step(lfsr_q);
        random_val_d = random_val_q;
        if (wr_en_s && is_io_s && (io_off_s == OFF_RANDOM)) begin
            if (writedata == {WIDTH{1'b0}}) begin
                lfsr_d = LFSR_SEED;
            end else begin
                lfsr_d = writedata;
            end
        end else begin
            lfsr_d = lfsr_step(lfsr_q);
        end
        if (wr_en_s && is_io_s && (io_off_s == OFF_RANDLATCH)) begin
            random_val_d = writedata;
        end else begin
            random_val_d = random_val_q;
        end
    end

    // Player channel handshakes. A PVAL read takes priority over a capture
    // in the same cycle so the CPU never loses a value it has not yet seen;
    // the producer is still holding valid and gets captured next cycle.
    always_comb begin
        pending_d = pending_q;
        p_ack_d   = {NPLAYERS{1'b0}};
        pval_d    = pval_q;
        for (int i = 0; i < NPLAYERS; i++) begin
            if (rd_en_s && pval_sel_s[i]) begin
                pending_d[i] = 1'b0;
            end else if (!pending_q[i] && p_valid[i]) begin
                pending_d[i] = 1'b1;
                p_ack_d[i]   = 1'b1;
                pval_d[i]    = p_data[i*WIDTH +: WIDTH];
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
        irq_d = |pending_d;
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------

    // RAM write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !is_io_s) begin
            ram[adr] <= writedata;
        end
    end

    // Output, LFSR and handshake state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memdata_q     <= {WIDTH{1'b0}};
            instruction_q <= {WIDTH{1'b0}};
            random_val_q  <= {WIDTH{1'b0}};
            lfsr_q        <= LFSR_SEED;
            pending_q     <= {NPLAYERS{1'b0}};
            p_ack_q       <= {NPLAYERS{1'b0}};
            irq_q         <= 1'b0;
            for (int i = 0; i < NPLAYERS; i++) begin
                pval_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            memdata_q     <= memdata_d;
            instruction_q <= instruction_d;
            random_val_q  <= random_val_d;
            lfsr_q        <= lfsr_d;
            pending_q     <= pending_d;
            p_ack_q       <= p_ack_d;
            irq_q         <= irq_d;
            for (int i = 0; i < NPLAYERS; i++) begin
                pval_q[i] <= pval_d[i];
            end
        end
    end

    assign memdata     = memdata_q;
    assign instruction = instruction_q;
    assign randomVal   = random_val_q;
    assign p_ack       = p_ack_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_mmio_exmem.sv
// -----------------------------------------------------------------------------
// tb_mmio_exmem
//
// Self-checking bench for mmio_exmem with default parameters. A behavioural
// model (RAM array, LFSR integer, pending flags, latched values) is advanced
// once per clock from the current inputs; scenario tasks compare DUT outputs
// against fixed values and against the model, and a randomized traffic task
// compares every output each cycle.
// -----------------------------------------------------------------------------
module tb_mmio_exmem;

    localparam int          NP   = 4;
    localparam logic [7:0]  IOB  = 8'hF0;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, memwrite, memread;
    logic [7:0]  adr, pc;
    logic [15:0] writedata;
    logic [3:0]  p_valid;
    logic [63:0] p_data;
    logic [15:0] memdata, instruction, randomVal;
    logic [3:0]  p_ack;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mmio_exmem dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .memwrite   (memwrite),
        .memread    (memread),
        .adr        (adr),
        .writedata  (writedata),
        .pc         (pc),
        .p_valid    (p_valid),
        .p_data     (p_data),
        .memdata    (memdata),
        .instruction(instruction),
        .randomVal  (randomVal),
        .p_ack      (p_ack),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_mem   [0:239];
    bit          m_known [0:239];
    logic [15:0] m_lfsr, m_rv, m_md, m_instr;
    bit          m_md_known, m_instr_known;
    logic [3:0]  m_pend, m_ack;
    logic [15:0] m_pval [0:3];

    function automatic logic [15:0] next_rand(input logic [15:0] v);
        logic [15:0] r;
        r = v / 16'd2;
        if (v % 16'd2 == 16'd1) r = r ^ TAPS;
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_rv = 16'h0000; m_md = 16'h0000; m_instr = 16'h0000;
        m_md_known = 1'b1; m_instr_known = 1'b1;
        m_pend = 4'b0000; m_ack = 4'b0000;
        for (int i = 0; i < NP; i++) m_pval[i] = 16'h0000;
    endtask

    task automatic idle();
        en = 1'b0; memwrite = 1'b0; memread = 1'b0; adr = 8'h00;
        writedata = 16'h0000; p_valid = 4'b0000;
    endtask

    // Compute the model's post-edge state from the present inputs, clock once,
    // commit, then step 1 time unit past the edge for sampling.
    task automatic tick();
        logic [15:0] n_md, n_instr, n_lfsr, n_rv;
        bit          n_md_known, n_instr_known, rd, wr, io;
        logic [3:0]  n_pend, n_ack;
        logic [15:0] n_pval [0:3];
        int          off;
        rd  = en && memread;
        wr  = en && memwrite;
        io  = (adr >= IOB);
        off = int'(adr) - int'(IOB);
        n_md = m_md; n_md_known = m_md_known;
        if (rd) begin
            n_md_known = 1'b1;
            if (!io) begin
                n_md = m_mem[adr]; n_md_known = m_known[adr];
            end else if (off == 0)                  n_md = m_lfsr;
            else if (off == 1)                      n_md = {12'h000, m_pend};
            else if (off >= 2 && off < 2 + NP)      n_md = m_pval[off-2];
            else if (off == 2 + NP)                 n_md = m_rv;
            else                                    n_md = 16'h0000;
        end
        if (pc < IOB) begin
            n_instr = m_mem[pc]; n_instr_known = m_known[pc];
        end else begin
            n_instr = 16'h0000; n_instr_known = 1'b1;
        end
        if (wr && io && off == 0) n_lfsr = (writedata == 16'h0000) ? SEED : writedata;
        else                      n_lfsr = next_rand(m_lfsr);
        n_rv = (wr && io && off == 2 + NP) ? writedata : m_rv;
        n_pend = m_pend; n_ack = 4'b0000;
        for (int i = 0; i < NP; i++) n_pval[i] = m_pval[i];
        for (int i = 0; i < NP; i++) begin
            if (rd && io && off == 2 + i) begin
                n_pend[i] = 1'b0;
            end else if (!m_pend[i] && p_valid[i]) begin
                n_pend[i] = 1'b1; n_ack[i] = 1'b1; n_pval[i] = p_data[i*16 +: 16];
            end
        end
        @(posedge clk);
        if (wr && !io) begin
            m_mem[adr] = writedata; m_known[adr] = 1'b1;
        end
        m_md = n_md; m_md_known = n_md_known;
        m_instr = n_instr; m_instr_known = n_instr_known;
        m_lfsr = n_lfsr; m_rv = n_rv; m_pend = n_pend; m_ack = n_ack;
        for (int i = 0; i < NP; i++) m_pval[i] = n_pval[i];
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); pc = 8'h00; p_data = 64'h0; rst = 1'b0;
        for (int i = 0; i < 240; i++) m_known[i] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (memdata !== 16'h0000) begin failures++; $display("FAIL reset_memdata got %h want 0000", memdata); end
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL reset_instr got %h want 0000", instruction); end
        checks++; if (randomVal !== 16'h0000) begin failures++; $display("FAIL reset_randomVal got %h want 0000", randomVal); end
        checks++; if (p_ack !== 4'b0000 || irq !== 1'b0) begin failures++; $display("FAIL reset_ack_irq got %b/%b want 0000/0", p_ack, irq); end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        idle(); en = 1'b1; memread = 1'b1; adr = IOB;
        tick();
        checks++; if (memdata !== 16'hACE1) begin failures++; $display("FAIL rand_first got %h want ace1", memdata); end
        tick();
        checks++; if (memdata !== m_md || memdata === 16'h0000) begin failures++; $display("FAIL rand_second got %h want %h", memdata, m_md); end
        memread = 1'b0; memwrite = 1'b1; writedata = 16'h0000;
        tick();
        memwrite = 1'b0; memread = 1'b1;
        tick();
        checks++; if (memdata !== 16'hACE1) begin failures++; $display("FAIL rand_zero_reseed got %h want ace1", memdata); end
        memread = 1'b0; memwrite = 1'b1; writedata = 16'h1357;
        tick();
        memwrite = 1'b0; memread = 1'b1;
        tick();
        checks++; if (memdata !== 16'h1357) begin failures++; $display("FAIL rand_reseed got %h want 1357", memdata); end
    endtask

    task automatic test_ram();
        idle(); en = 1'b1; memwrite = 1'b1; adr = 8'd3; writedata = 16'h1234;
        tick();
        memwrite = 1'b0; memread = 1'b1;
        tick();
        checks++; if (memdata !== 16'h1234) begin failures++; $display("FAIL ram_read got %h want 1234", memdata); end
        memwrite = 1'b1; writedata = 16'h5678;
        tick();
        checks++; if (memdata !== 16'h1234) begin failures++; $display("FAIL ram_rbw got %h want 1234", memdata); end
        memwrite = 1'b0; pc = 8'd3;
        tick();
        checks++; if (memdata !== 16'h5678) begin failures++; $display("FAIL ram_after_write got %h want 5678", memdata); end
        checks++; if (instruction !== 16'h5678) begin failures++; $display("FAIL fetch_ram got %h want 5678", instruction); end
        memread = 1'b0; pc = 8'hF2;
        tick();
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL fetch_io got %h want 0000", instruction); end
        checks++; if (memdata !== 16'h5678) begin failures++; $display("FAIL memdata_hold got %h want 5678", memdata); end
    endtask

    task automatic test_player();
        idle(); p_valid[2] = 1'b1; p_data[47:32] = 16'h00AB;
        tick();
        checks++; if (p_ack !== 4'b0100 || irq !== 1'b1) begin failures++; $display("FAIL pl_capture got %b/%b want 0100/1", p_ack, irq); end
        tick();
        checks++; if (p_ack !== 4'b0000) begin failures++; $display("FAIL pl_ack_pulse got %b want 0000", p_ack); end
        en = 1'b1; memread = 1'b1; adr = IOB + 8'd1;
        tick();
        checks++; if (memdata !== 16'h0004) begin failures++; $display("FAIL pl_status got %h want 0004", memdata); end
        memread = 1'b0; p_data[47:32] = 16'h00CD;
        tick();
        checks++; if (p_ack !== 4'b0000) begin failures++; $display("FAIL pl_full_noack got %b want 0000", p_ack); end
        memread = 1'b1; adr = IOB + 8'd4;
        tick();
        checks++; if (memdata !== 16'h00AB || p_ack !== 4'b0000 || irq !== 1'b0) begin failures++; $display("FAIL pl_pval_read got %h/%b/%b want 00ab/0000/0", memdata, p_ack, irq); end
        memread = 1'b0;
        tick();
        checks++; if (p_ack !== 4'b0100 || irq !== 1'b1) begin failures++; $display("FAIL pl_recapture got %b/%b want 0100/1", p_ack, irq); end
        p_valid = 4'b0000; memread = 1'b1;
        tick();
        checks++; if (memdata !== 16'h00CD || irq !== 1'b0) begin failures++; $display("FAIL pl_second_val got %h/%b want 00cd/0", memdata, irq); end
    endtask

    task automatic test_clear_race();
        idle(); en = 1'b1; memread = 1'b1; adr = IOB + 8'd2;
        p_valid[0] = 1'b1; p_data[15:0] = 16'h0042;
        tick();
        checks++; if (p_ack !== 4'b0000 || irq !== 1'b0) begin failures++; $display("FAIL race_noack got %b/%b want 0000/0", p_ack, irq); end
        memread = 1'b0;
        tick();
        checks++; if (p_ack !== 4'b0001) begin failures++; $display("FAIL race_late_ack got %b want 0001", p_ack); end
        p_valid = 4'b0000; memread = 1'b1; adr = IOB + 8'd1;
        tick();
        checks++; if (memdata !== 16'h0001) begin failures++; $display("FAIL race_status got %h want 0001", memdata); end
        adr = IOB + 8'd2;
        tick();
        checks++; if (memdata !== 16'h0042) begin failures++; $display("FAIL race_pval got %h want 0042", memdata); end
    endtask

    task automatic test_randlatch();
        idle(); en = 1'b1; memwrite = 1'b1; adr = IOB + 8'd6; writedata = 16'hBEEF;
        tick();
        checks++; if (randomVal !== 16'hBEEF) begin failures++; $display("FAIL rl_write got %h want beef", randomVal); end
        memwrite = 1'b0; memread = 1'b1;
        tick();
        checks++; if (memdata !== 16'hBEEF) begin failures++; $display("FAIL rl_read got %h want beef", memdata); end
        adr = IOB + 8'd7;
        tick();
        checks++; if (memdata !== 16'h0000) begin failures++; $display("FAIL unmapped_read got %h want 0000", memdata); end
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 400; c++) begin
            en = 1'($urandom_range(0, 3) != 0);
            memwrite = 1'($urandom_range(0, 2) == 0);
            memread  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 247));
            writedata = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            pc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 15));
            p_valid = 4'($urandom);
            p_data = {32'($urandom), 32'($urandom)};
            tick();
            if (m_md_known) begin
                checks++; if (memdata !== m_md) begin failures++; $display("FAIL rnd_memdata cyc %0d got %h want %h", c, memdata, m_md); end
            end
            if (m_instr_known) begin
                checks++; if (instruction !== m_instr) begin failures++; $display("FAIL rnd_instr cyc %0d got %h want %h", c, instruction, m_instr); end
            end
            checks++; if (randomVal !== m_rv) begin failures++; $display("FAIL rnd_randomVal cyc %0d got %h want %h", c, randomVal, m_rv); end
            checks++; if (p_ack !== m_ack) begin failures++; $display("FAIL rnd_ack cyc %0d got %b want %b", c, p_ack, m_ack); end
            checks++; if (irq !== (|m_pend)) begin failures++; $display("FAIL rnd_irq cyc %0d got %b want %b", c, irq, |m_pend); end
        end
    endtask

    task automatic test_reset_mid();
        idle(); en = 1'b1; memwrite = 1'b1; adr = 8'd5; writedata = 16'hC0DE;
        tick();
        memwrite = 1'b0; p_valid = 4'b1111; p_data = 64'h1111_2222_3333_4444;
        tick();
        p_valid = 4'b0000; memwrite = 1'b1; adr = IOB + 8'd6; writedata = 16'h5A5A;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (p_ack !== 4'b0000 || irq !== 1'b0) begin failures++; $display("FAIL midrst_ack_irq got %b/%b want 0000/0", p_ack, irq); end
        checks++; if (randomVal !== 16'h0000 || memdata !== 16'h0000 || instruction !== 16'h0000) begin failures++; $display("FAIL midrst_outputs got %h/%h/%h want 0", randomVal, memdata, instruction); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        idle(); pc = 8'd5; en = 1'b1; memread = 1'b1; adr = IOB;
        tick();
        checks++; if (instruction !== 16'hC0DE) begin failures++; $display("FAIL midrst_ram_kept got %h want c0de", instruction); end
        checks++; if (memdata !== 16'hACE1) begin failures++; $display("FAIL midrst_lfsr got %h want ace1", memdata); end
        memread = 1'b1; adr = IOB + 8'd1;
        tick();
        checks++; if (memdata !== 16'h0000) begin failures++; $display("FAIL midrst_status got %h want 0000", memdata); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_ram();
        test_player();
        test_clear_race();
        test_randlatch();
        test_random_traffic();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
